// File: rtl/eightbit_ser_tx_if.sv
// Byte handshake bundle for the serial transmitter.
// in_data/in_val from producer, in_rdy back from transmitter.
interface eightbit_ser_tx_if;
  logic [7:0] in_data;
  logic       in_val;
  logic       in_rdy;

  modport master (
    output in_data,
    output in_val,
    input  in_rdy
  );

  modport slave (
    input  in_data,
    input  in_val,
    output in_rdy
  );
endinterface

// File: rtl/eightbit_ser_tx.sv
// 8N1 serial transmitter: start bit, 8 data LSB first, stop bit.
// Ports: clk, reset (async high), s (byte handshake), tx, busy.
module eightbit_ser_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  eightbit_ser_tx_if.slave s,
  output logic             tx,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [7:0] CMAX = 8'(CLKS_PER_BIT - 1);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [2:0] idx, idx_d;
  logic [7:0] sh, sh_d;
  logic       tx_d;
  logic       bit_end;

  assign bit_end  = (cnt == CMAX);
  assign s.in_rdy = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      sh    <= sh_d;
      tx    <= tx_d;
    end
  end

  // tx is registered from the next-state value so
  // each bit appears on the line in its own first cycle.
  always_comb begin
    state_d = state;
    cnt_d   = bit_end ? 8'd0 : cnt + 8'd1;
    idx_d   = idx;
    sh_d    = sh;
    tx_d    = tx;
    unique case (1'b1)
      (state == IDLE): begin
        cnt_d = '0;
        idx_d = '0;
        tx_d  = 1'b1;
        if (s.in_val) begin
          state_d = START;
          sh_d    = s.in_data;
          tx_d    = 1'b0;
        end
      end
      (state == START): begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = sh[0];
        end
      end
      (state == DATA): begin
        if (bit_end) begin
          idx_d = idx + 3'd1;
          if (idx == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            sh_d = sh >> 1;
            tx_d = sh[1];
          end
        end
      end
      (state == STOP): begin
        tx_d = 1'b1;
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

`ifdef FORMAL
  always_comb begin
    if (!reset) begin
      if (state == IDLE || state == STOP) begin
        assert (tx);
      end
      assert (s.in_rdy == !busy);
      assert (cnt < 8'(CLKS_PER_BIT));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && idx_d != idx) begin
      assert (bit_end);
    end
  end
`endif

endmodule

// File: doc/eightbit_ser_tx.md
EIGHTBIT_SER_TX -- requirements
Module: eightbit_ser_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, number of clk cycles each serial bit is held on tx (legal range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_data  input  8  parallel byte to transmit; sampled only at handshake.
REQ-005 in_val  input  1  producer asserts when in_data is valid.
REQ-006 in_rdy  output  1  block can accept a byte this cycle.
REQ-007 tx  output  1  serial line; idle-high, registered.
REQ-008 busy  output  1  a frame is in progress (any state other than IDLE).

Function
REQ-009 The block SHALL implement the states IDLE, START, DATA and STOP.
REQ-010 in_rdy SHALL be 1 exactly when state == IDLE, with no combinational path from in_val to in_rdy.
REQ-011 A handshake occurs on a rising edge where in_val && in_rdy; in_data SHALL be latched into an internal 8-bit shift register on that edge.
REQ-012 On handshake, the next state SHALL be START, with tx = 0 from the following cycle.
REQ-013 Each of START, each DATA bit and STOP SHALL hold tx for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that resets to 0 at every bit boundary.
REQ-014 DATA SHALL send 8 bits LSB first, tracked by a 3-bit bit index that runs from 0 to 7.
REQ-015 After bit 7 the block SHALL enter STOP (tx = 1); after STOP it SHALL return to IDLE (tx = 1).
REQ-016 One frame SHALL occupy tx for 10*CLKS_PER_BIT cycles, measured from the first cycle of START through the last cycle of STOP.
REQ-017 Back-to-back frames: with in_val held high, the block SHALL spend exactly one cycle in IDLE between the end of STOP and the next START, so the frame period is 10*CLKS_PER_BIT+1 cycles.
REQ-018 While state != IDLE, in_val and in_data SHALL be ignored, and the frame in flight SHALL be unaffected by input changes.
REQ-019 busy SHALL equal (state != IDLE) and SHALL be registered-state derived.
REQ-020 In IDLE, tx SHALL be 1 at all times; tx SHALL never glitch low except in START or on a DATA bit of 0.
REQ-021 With CLKS_PER_BIT = 1, each bit SHALL last exactly one cycle, and the frame SHALL be 10 cycles.
REQ-022 Under `ifdef FORMAL, the block SHALL carry assertions that:
  - tx == 1 whenever state is IDLE or STOP;
  - in_rdy == !busy;
  - the bit-period counter < CLKS_PER_BIT;
  - the bit index changes only at a bit boundary.

Reset
REQ-023 While reset = 1, regardless of clk:
  - state = IDLE;
  - tx = 1;
  - in_rdy = 1;
  - busy = 0;
  - bit-period counter = 0;
  - bit index = 0;
  - shift register = 8'h00.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, with no partial bits after deassertion.
REQ-025 After reset deasserts, the first handshake SHALL be accepted on the first rising edge with in_val = 1.

Verification (CLKS_PER_BIT = 4 unless stated)
REQ-026 Send 8'hA5 -> tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; busy high for 40 cycles; in_rdy low for the same 40 cycles.
REQ-027 Back-to-back 8'h00 then 8'hFF with in_val held -> second START begins exactly 41 cycles after the first START; second frame is tx = 0 (4 cycles), then 1 for 36 cycles.
REQ-028 Change in_data from 8'h3C to 8'h00 during DATA while in_val = 1 -> transmitted bits still match 8'h3C (0,0,1,1,1,1,0,0).
REQ-029 Assert reset in bit 3 of a frame -> tx = 1, busy = 0, in_rdy = 1 in the same cycle; after release, sending 8'h81 produces a clean, complete frame.
REQ-030 CLKS_PER_BIT = 1, send 8'h01 -> tx sequence 0,1,0,0,0,0,0,0,0,1 over 10 consecutive cycles.
REQ-031 in_val = 0 for 20 cycles after reset -> tx stays 1, busy stays 0, in_rdy stays 1 throughout.
